// File: rtl/interlaken_pkg.sv
// Shared Interlaken lane constants: header codes, word widths and the
// position of the inversion flag within a 67-bit lane word.
package interlaken_pkg;

    localparam int LANE_W    = 67;
    localparam int PAYLOAD_W = 64;
    localparam int RD_W      = 8;
    localparam int INV_BIT   = 66;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

endpackage

// File: rtl/popcount64.sv
// Combinational population count of a 64-bit word, built as a six-level
// balanced adder tree so that each level only widens by one bit.
module popcount64 (
    input  logic [63:0] data,
    output logic [6:0]  count
);

    logic [1:0] sum_l1 [32];
    logic [2:0] sum_l2 [16];
    logic [3:0] sum_l3 [8];
    logic [4:0] sum_l4 [4];
    logic [5:0] sum_l5 [2];

    genvar gi;

    // Level 1: add adjacent bit pairs.
    generate
        for (gi = 0; gi < 32; gi++) begin : g_l1
            assign sum_l1[gi] = {1'b0, data[2*gi]} + {1'b0, data[2*gi+1]};
        end
        // Level 2: 2-bit partial sums into 3-bit sums.
        for (gi = 0; gi < 16; gi++) begin : g_l2
            assign sum_l2[gi] = {1'b0, sum_l1[2*gi]} + {1'b0, sum_l1[2*gi+1]};
        end
        // Level 3
        for (gi = 0; gi < 8; gi++) begin : g_l3
            assign sum_l3[gi] = {1'b0, sum_l2[2*gi]} + {1'b0, sum_l2[2*gi+1]};
        end
        // Level 4
        for (gi = 0; gi < 4; gi++) begin : g_l4
            assign sum_l4[gi] = {1'b0, sum_l3[2*gi]} + {1'b0, sum_l3[2*gi+1]};
        end
        // Level 5
        for (gi = 0; gi < 2; gi++) begin : g_l5
            assign sum_l5[gi] = {1'b0, sum_l4[2*gi]} + {1'b0, sum_l4[2*gi+1]};
        end
    endgenerate

    // Root of the tree: final 7-bit count (0..64).
    assign count = {1'b0, sum_l5[0]} + {1'b0, sum_l5[1]};

endmodule

// File: rtl/encode_64b_67b.sv
// Interlaken 64B/67B transmit encoder. Stage 1 registers the incoming word
// together with its popcount; stage 2 compares the payload disparity sign
// with the running disparity, decides whether to invert, and registers the
// 67-bit lane word and the updated running disparity.
module encode_64b_67b
    import interlaken_pkg::*;
(
    input  logic                 USER_CLK,
    input  logic                 SYSTEM_RESET_N,
    input  logic [PAYLOAD_W-1:0] DATA_IN,
    input  logic [1:0]           HEADER_IN,
    input  logic                 DATA_IN_VALID,
    input  logic                 PASSTHROUGH,
    output logic [LANE_W-1:0]    DATA_OUT,
    output logic                 DATA_OUT_VALID,
    output logic                 HEADER_ERR,
    output logic [RD_W-1:0]      RUNNING_DISPARITY
);

    // Stage 1 registers
    logic [PAYLOAD_W-1:0] data_s1_reg;
    logic [1:0]           header_s1_reg;
    logic                 valid_s1_reg;
    logic [6:0]           pop_s1_reg;
    logic [6:0]           pop_next;

    // Stage 2 registers
    logic [LANE_W-1:0]      dout_reg;
    logic [LANE_W-1:0]      dout_next;
    logic                   dout_valid_reg;
    logic                   header_err_reg;
    logic                   header_err_next;
    logic signed [RD_W-1:0] rd_reg;
    logic signed [RD_W-1:0] rd_next;

    // Stage 2 decision terms; 10 bits leave headroom for RD +/- Dp +/- 1.
    logic signed [9:0] dp_ext;
    logic signed [9:0] rd_ext;
    logic signed [9:0] rd_calc;
    logic              rd_pos;
    logic              rd_neg;
    logic              dp_pos;
    logic              dp_neg;
    logic              invert;

    popcount64 u_popcount (
        .data  (DATA_IN),
        .count (pop_next)
    );

    // Stage 1: capture the word, its qualifier and its popcount.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            data_s1_reg   <= '0;
            header_s1_reg <= '0;
            valid_s1_reg  <= 1'b0;
            pop_s1_reg    <= '0;
        end else begin
            data_s1_reg   <= DATA_IN;
            header_s1_reg <= HEADER_IN;
            valid_s1_reg  <= DATA_IN_VALID;
            pop_s1_reg    <= pop_next;
        end
    end

    // Stage 2 combinational: inversion decision, lane word and next RD.
    always_comb begin
        dp_ext  = $signed({2'b00, pop_s1_reg, 1'b0}) - 10'sd64;
        rd_ext  = {{2{rd_reg[RD_W-1]}}, rd_reg};
        rd_neg  = rd_reg[RD_W-1];
        rd_pos  = !rd_reg[RD_W-1] && (rd_reg != '0);
        dp_pos  = pop_s1_reg > 7'd32;
        dp_neg  = pop_s1_reg < 7'd32;
        invert  = !PASSTHROUGH && ((rd_pos && dp_pos) || (rd_neg && dp_neg));
        rd_calc = invert ? (rd_ext - dp_ext + 10'sd1) : (rd_ext + dp_ext - 10'sd1);

        dout_next                       = dout_reg;
        rd_next                         = rd_reg;
        header_err_next                 = 1'b0;
        if (valid_s1_reg) begin
            dout_next[INV_BIT]          = invert;
            dout_next[INV_BIT-1 -: 2]   = header_s1_reg;
            dout_next[PAYLOAD_W-1:0]    = invert ? ~data_s1_reg : data_s1_reg;
            rd_next                     = PASSTHROUGH ? '0 : rd_calc[RD_W-1:0];
            header_err_next             = (header_s1_reg != HDR_DATA) &&
                                          (header_s1_reg != HDR_CTRL);
        end
    end

    // Stage 2 registers: lane word, qualifiers and running disparity.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            header_err_reg <= 1'b0;
            rd_reg         <= '0;
        end else begin
            dout_reg       <= dout_next;
            dout_valid_reg <= valid_s1_reg;
            header_err_reg <= header_err_next;
            rd_reg         <= rd_next;
        end
    end

    assign DATA_OUT          = dout_reg;
    assign DATA_OUT_VALID    = dout_valid_reg;
    assign HEADER_ERR        = header_err_reg;
    assign RUNNING_DISPARITY = rd_reg;

endmodule
